// File: rtl/esm_pkg.sv
// Shared types for the ESM PLL lock sequencer: FSM state encoding, the latched
// request record, and a counter-width helper.
package esm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APPLY    = 3'd1,
    PRELOCK  = 3'd2,
    LOCK     = 3'd3,
    POSTLOCK = 3'd4,
    DONE     = 3'd5
  } esm_pll_seq_state_t;

  typedef struct packed {
    logic [2:0] profile;
    logic       skip_prelock;
    logic       skip_lock_check;
    logic       skip_postlock;
  } esm_pll_request_t;

  localparam int ESM_AD9361_CTRL_W   = 4;
  localparam int ESM_AD9361_STATUS_W = 8;

  // Width for a counter reaching n; never narrower than one bit.
  function automatic int esm_cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/esm_ad9361_status_sync.sv
// Two-flop synchronizer bringing the asynchronous AD9361 CTRL_OUT status pins
// into the Clk domain.
module esm_ad9361_status_sync
  import esm_pkg::*;
#(
  parameter int W = ESM_AD9361_STATUS_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/esm_pll_lock_sequencer.sv
// Per-dwell AD9361 fast-lock profile recall: apply profile, pre-lock wait,
// poll synced PLL lock with timeout, post-lock wait, then pulse Done.
module esm_pll_lock_sequencer
  import esm_pkg::*;
#(
  parameter int PLL_PRE_LOCK_DELAY_CYCLES  = 8,
  parameter int PLL_POST_LOCK_DELAY_CYCLES = 10,
  parameter int LOCK_TIMEOUT_CYCLES        = 4096,
  parameter int LOCK_STATUS_BIT            = 0
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           Req_valid,
  output logic                           Req_ready,
  input  logic [2:0]                     Req_profile,
  input  logic                           Req_skip_prelock,
  input  logic                           Req_skip_lock_check,
  input  logic                           Req_skip_postlock,
  input  logic                           Abort,
  output logic [ESM_AD9361_CTRL_W-1:0]   Ad9361_control,
  input  logic [ESM_AD9361_STATUS_W-1:0] Ad9361_status,
  output logic                           Done,
  output logic                           Done_timeout,
  output logic                           Busy,
  output logic [15:0]                    Timeout_count,
  output esm_pll_seq_state_t             Dbg_state
);

  localparam int PRE_W  = esm_cnt_width(PLL_PRE_LOCK_DELAY_CYCLES);
  localparam int LOCK_W = esm_cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam int POST_W = esm_cnt_width(PLL_POST_LOCK_DELAY_CYCLES);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'((PLL_PRE_LOCK_DELAY_CYCLES > 0) ?
                                                   PLL_PRE_LOCK_DELAY_CYCLES - 1 : 0);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'((LOCK_TIMEOUT_CYCLES > 0) ?
                                                    LOCK_TIMEOUT_CYCLES - 1 : 0);
  localparam logic [POST_W-1:0] POST_LAST = POST_W'((PLL_POST_LOCK_DELAY_CYCLES > 0) ?
                                                    PLL_POST_LOCK_DELAY_CYCLES - 1 : 0);

  // Handshake: a request transfers on any edge where Req_valid && Req_ready;
  // Req_ready is high only in IDLE, and the request fields are sampled on that edge.

  esm_pll_seq_state_t r_state;
  esm_pll_seq_state_t w_next;
  esm_pll_request_t   r_req;
  logic [ESM_AD9361_CTRL_W-1:0]   r_ctrl;
  logic                           r_timeout;
  logic [15:0]                    r_tcount;
  logic [PRE_W-1:0]               r_pre_cnt;
  logic [LOCK_W-1:0]              r_lock_cnt;
  logic [POST_W-1:0]              r_post_cnt;
  logic [ESM_AD9361_STATUS_W-1:0] w_status_sync;
  logic                           w_lock;
  logic                           w_accept;
  logic                           w_set_timeout;
  logic                           w_unused_status;

  esm_ad9361_status_sync #(
    .W(ESM_AD9361_STATUS_W)
  ) u_status_sync (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_async (Ad9361_status),
    .o_sync  (w_status_sync)
  );

  assign w_lock          = w_status_sync[LOCK_STATUS_BIT];
  assign w_unused_status = ^w_status_sync;
  assign w_accept        = (r_state == IDLE) && Req_valid;

  // Skipped or zero-length waits fall through to the next enabled stage.
  function automatic esm_pll_seq_state_t after_lock(input esm_pll_request_t rq);
    return (!rq.skip_postlock && (PLL_POST_LOCK_DELAY_CYCLES > 0)) ? POSTLOCK : DONE;
  endfunction

  function automatic esm_pll_seq_state_t after_prelock(input esm_pll_request_t rq);
    return (!rq.skip_lock_check) ? LOCK : after_lock(rq);
  endfunction

  function automatic esm_pll_seq_state_t after_apply(input esm_pll_request_t rq);
    return (!rq.skip_prelock && (PLL_PRE_LOCK_DELAY_CYCLES > 0)) ? PRELOCK : after_prelock(rq);
  endfunction

  always_comb begin
    w_next        = r_state;
    w_set_timeout = 1'b0;
    case (r_state)
      IDLE:     if (Req_valid) w_next = APPLY;
      APPLY:    w_next = Abort ? IDLE : after_apply(r_req);
      PRELOCK: begin
        if (Abort)                       w_next = IDLE;
        else if (r_pre_cnt == PRE_LAST)  w_next = after_prelock(r_req);
      end
      LOCK: begin
        if (Abort)                       w_next = IDLE;
        else if (w_lock)                 w_next = after_lock(r_req);
        else if (r_lock_cnt == LOCK_LAST) begin
          w_next        = DONE;
          w_set_timeout = 1'b1;
        end
      end
      POSTLOCK: begin
        if (Abort)                       w_next = IDLE;
        else if (r_post_cnt == POST_LAST) w_next = DONE;
      end
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_ctrl     <= '0;
      r_timeout  <= 1'b0;
      r_tcount   <= '0;
      r_pre_cnt  <= '0;
      r_lock_cnt <= '0;
      r_post_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_req.profile         <= Req_profile;
        r_req.skip_prelock    <= Req_skip_prelock;
        r_req.skip_lock_check <= Req_skip_lock_check;
        r_req.skip_postlock   <= Req_skip_postlock;
        r_ctrl                <= {1'b1, Req_profile};
        r_timeout             <= 1'b0;
      end else if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
      if ((r_state == DONE) && r_timeout && (r_tcount != 16'hFFFF))
        r_tcount <= r_tcount + 16'd1;
      // Each counter sits at zero outside its own state, so entry always starts at zero.
      r_pre_cnt  <= (r_state == PRELOCK)  ? r_pre_cnt + 1'b1  : '0;
      r_lock_cnt <= (r_state == LOCK)     ? r_lock_cnt + 1'b1 : '0;
      r_post_cnt <= (r_state == POSTLOCK) ? r_post_cnt + 1'b1 : '0;
    end
  end

  assign Req_ready      = (r_state == IDLE);
  assign Busy           = (r_state != IDLE);
  assign Done           = (r_state == DONE);
  assign Done_timeout   = (r_state == DONE) && r_timeout;
  assign Ad9361_control = r_ctrl;
  assign Timeout_count  = r_tcount;
  assign Dbg_state      = r_state;

endmodule

// File: tb/tb_esm_pll_lock_sequencer.sv
// Bench for esm_pll_lock_sequencer: directed dwell scenarios plus a random
// back-to-back run, checked against an expected-Done queue.
module tb_esm_pll_lock_sequencer;
  import esm_pkg::*;

  localparam int PRE  = 8;
  localparam int POST = 10;
  localparam int TMO  = 64;
  localparam int EW   = 37;  // {timeout, control[3:0], done_cycle[31:0]}

  logic               Clk;
  logic               Rst_n;
  logic               Req_valid;
  logic               Req_ready;
  logic [2:0]         Req_profile;
  logic               Req_skip_prelock;
  logic               Req_skip_lock_check;
  logic               Req_skip_postlock;
  logic               Abort;
  logic [3:0]         Ad9361_control;
  logic [7:0]         Ad9361_status;
  logic               Done;
  logic               Done_timeout;
  logic               Busy;
  logic [15:0]        Timeout_count;
  esm_pll_seq_state_t Dbg_state;

  esm_pll_lock_sequencer #(
    .PLL_PRE_LOCK_DELAY_CYCLES  (PRE),
    .PLL_POST_LOCK_DELAY_CYCLES (POST),
    .LOCK_TIMEOUT_CYCLES        (TMO),
    .LOCK_STATUS_BIT            (0)
  ) dut (
    .Clk                 (Clk),
    .Rst_n               (Rst_n),
    .Req_valid           (Req_valid),
    .Req_ready           (Req_ready),
    .Req_profile         (Req_profile),
    .Req_skip_prelock    (Req_skip_prelock),
    .Req_skip_lock_check (Req_skip_lock_check),
    .Req_skip_postlock   (Req_skip_postlock),
    .Abort               (Abort),
    .Ad9361_control      (Ad9361_control),
    .Ad9361_status       (Ad9361_status),
    .Done                (Done),
    .Done_timeout        (Done_timeout),
    .Busy                (Busy),
    .Timeout_count       (Timeout_count),
    .Dbg_state           (Dbg_state)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;
  int pushed    = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every Done pops one expectation.
  always @(negedge Clk) begin
    logic [EW-1:0] e;
    if (Rst_n && Done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check_eq("done_with_empty_queue", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("done_cycle",   64'(cyc),            64'(e[31:0]));
        check_eq("done_timeout", 64'(Done_timeout),   64'(e[36]));
        check_eq("done_ctrl",    64'(Ad9361_control), 64'(e[35:32]));
      end
    end
  end

  // Driver: called at posedge+#1, returns at posedge+#1 of the APPLY cycle.
  task automatic do_req(input logic [2:0] prof, input logic sp, input logic sl, input logic spo,
                        input int lat, input logic exp_to, input bit expect_done);
    int unsigned n = 0;
    bit got = 1'b0;
    Req_valid           = 1'b1;
    Req_profile         = prof;
    Req_skip_prelock    = sp;
    Req_skip_lock_check = sl;
    Req_skip_postlock   = spo;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge Clk);
      if (Req_ready) begin
        got = 1'b1;
        n   = cyc;
      end else begin
        @(posedge Clk); #1;
      end
    end
    check_eq("req_accepted", 64'(got), 64'd1);
    if (got && expect_done) begin
      exp_q.push_back({exp_to, 1'b1, prof, 32'(n + 32'(lat))});
      pushed++;
    end
    @(posedge Clk); #1;
    Req_valid = 1'b0;
    check_eq("ctrl_after_accept", 64'(Ad9361_control), 64'({1'b1, prof}));
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge Clk);
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    @(posedge Clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctrl"},     64'(Ad9361_control), 64'd0);
    check_eq({tag, "_done"},     64'(Done),           64'd0);
    check_eq({tag, "_dtimeout"}, 64'(Done_timeout),   64'd0);
    check_eq({tag, "_busy"},     64'(Busy),           64'd0);
    check_eq({tag, "_tcount"},   64'(Timeout_count),  64'd0);
    check_eq({tag, "_ready"},    64'(Req_ready),      64'd1);
  endtask

  initial begin
    logic [2:0] prof;
    logic sp, sl, spo;
    int lat;
    bit seen_done;

    Rst_n = 1'b1;
    Req_valid = 1'b0; Req_profile = '0;
    Req_skip_prelock = 1'b0; Req_skip_lock_check = 1'b0; Req_skip_postlock = 1'b0;
    Abort = 1'b0; Ad9361_status = 8'h00;
    #2 Rst_n = 1'b0;
    #10;
    check_reset_outputs("reset");
    @(posedge Clk); #2 Rst_n = 1'b1;
    @(negedge Clk);
    check_eq("ready_after_release", 64'(Req_ready), 64'd1);
    check_eq("state_after_release", 64'(Dbg_state), 64'(IDLE));
    @(posedge Clk); #1;

    // 1: profile 5, no skips, lock already high
    Ad9361_status = 8'h01;
    repeat (3) begin @(posedge Clk); #1; end
    do_req(3'd5, 1'b0, 1'b0, 1'b0, 2 + PRE + 1 + POST, 1'b0, 1'b1);
    wait_drain(100);

    // 2: lock rises 30 cycles after APPLY; Ready stays low until Done
    Ad9361_status = 8'h00;
    repeat (3) begin @(posedge Clk); #1; end
    do_req(3'd1, 1'b0, 1'b0, 1'b0, 1 + 30 + 2 + 1 + POST, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      check_eq("ready_low_waiting", 64'(Req_ready), 64'd0);
      @(posedge Clk); #1;
    end
    Ad9361_status = 8'h01;
    seen_done = 1'b0;
    for (int i = 0; i < 100 && !seen_done; i++) begin
      @(negedge Clk);
      check_eq("ready_low_locking", 64'(Req_ready), 64'd0);
      seen_done = Done;
    end
    check_eq("lock_done_seen", 64'(seen_done), 64'd1);
    wait_drain(10);

    // 3: lock held low -> timeout after TMO cycles in LOCK, no post-lock
    Ad9361_status = 8'h00;
    repeat (3) begin @(posedge Clk); #1; end
    check_eq("tcount_before", 64'(Timeout_count), 64'd0);
    do_req(3'd6, 1'b0, 1'b0, 1'b0, 2 + PRE + TMO, 1'b1, 1'b1);
    wait_drain(200);
    check_eq("tcount_after", 64'(Timeout_count), 64'd1);

    // 4: all skips, profile 2
    Ad9361_status = 8'h01;
    repeat (3) begin @(posedge Clk); #1; end
    do_req(3'd2, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b1);
    check_eq("busy_apply", 64'(Busy), 64'd1);
    @(posedge Clk); #1;
    check_eq("busy_done", 64'(Busy), 64'd1);
    @(posedge Clk); #1;
    check_eq("busy_idle", 64'(Busy), 64'd0);
    wait_drain(10);

    // 5: abort in PRELOCK, then profile 7 in the very next IDLE cycle
    do_req(3'd3, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    @(posedge Clk); #1;
    check_eq("state_prelock", 64'(Dbg_state), 64'(PRELOCK));
    Abort = 1'b1;
    @(posedge Clk); #1;
    Abort = 1'b0;
    check_eq("abort_idle", 64'(Busy), 64'd0);
    check_eq("abort_ctrl_held", 64'(Ad9361_control), 64'hB);
    do_req(3'd7, 1'b0, 1'b0, 1'b0, 2 + PRE + 1 + POST, 1'b0, 1'b1);
    wait_drain(100);
    check_eq("tcount_after_abort", 64'(Timeout_count), 64'd1);

    // Abort during DONE is ignored; Abort in IDLE still lets a request through
    do_req(3'd4, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b1);
    @(posedge Clk); #1;
    Abort = 1'b1;
    @(posedge Clk); #1;
    Abort = 1'b0;
    wait_drain(10);
    Abort = 1'b1;
    do_req(3'd0, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b1);
    Abort = 1'b0;
    wait_drain(10);

    // 6: async reset in POSTLOCK
    do_req(3'd5, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    repeat (15) begin @(posedge Clk); #1; end
    check_eq("state_postlock", 64'(Dbg_state), 64'(POSTLOCK));
    #2 Rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge Clk);
    @(posedge Clk); #2 Rst_n = 1'b1;
    @(negedge Clk);
    check_eq("ready_after_rerelease", 64'(Req_ready), 64'd1);
    repeat (3) begin @(posedge Clk); #1; end

    // 1000 back-to-back random requests, lock held high
    for (int k = 0; k < 1000; k++) begin
      prof = 3'($urandom_range(0, 7));
      sp   = 1'($urandom_range(0, 1));
      sl   = 1'($urandom_range(0, 1));
      spo  = 1'($urandom_range(0, 1));
      lat  = 2 + (sp ? 0 : PRE) + (sl ? 0 : 1) + (spo ? 0 : POST);
      do_req(prof, sp, sl, spo, lat, 1'b0, 1'b1);
    end
    wait_drain(100);
    check_eq("done_count", 64'(done_seen), 64'(pushed));
    check_eq("tcount_random", 64'(Timeout_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
